// File: rtl/bus_transfer_controller_if.sv
// bus_transfer_controller_if: request/strobe bundle between control unit, sequencer and register bank.
interface bus_transfer_controller_if #(
   parameter int NUM_REGS  = 8,
   parameter int SEL_WIDTH = 3
) ();
   logic                 req;
   logic [SEL_WIDTH-1:0] src;
   logic [SEL_WIDTH-1:0] dst;
   logic                 busy;
   logic                 done;
   logic                 error;
   logic [NUM_REGS-1:0]  enable;
   logic [NUM_REGS-1:0]  latch;
   logic [15:0]          xfer_count;
   modport master (output req, src, dst, input busy, done, error, enable, latch, xfer_count);
   modport slave  (input req, src, dst, output busy, done, error, enable, latch, xfer_count);
endinterface

// File: rtl/bus_transfer_controller.sv
// bus_transfer_controller: break-before-make drive/capture strobe sequencer for a shared register bus.
module bus_transfer_controller #(
   parameter int NUM_REGS  = 8,
   parameter int SEL_WIDTH = 3
) (
   input logic clk,
   input logic reset,
   bus_transfer_controller_if.slave bus
);
   typedef enum logic [1:0] {IDLE, DRIVE, CAPTURE, DONE} state_t;
   state_t state;
   logic [SEL_WIDTH-1:0] dst_q;
   logic valid;
   function automatic logic [NUM_REGS-1:0] onehot(input logic [SEL_WIDTH-1:0] i);
      return NUM_REGS'(1) << i;
   endfunction
   // indices are widened so NUM_REGS == 2**SEL_WIDTH still compares correctly
   assign valid = bus.src != bus.dst && 32'(bus.src) < NUM_REGS && 32'(bus.dst) < NUM_REGS;
   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= IDLE;
         dst_q          <= '0;
         bus.busy       <= 1'b0;
         bus.done       <= 1'b0;
         bus.error      <= 1'b0;
         bus.enable     <= '0;
         bus.latch      <= '0;
         bus.xfer_count <= '0;
      end else begin
         bus.done  <= 1'b0;
         bus.error <= 1'b0;
         case (state)
            IDLE: begin
               bus.error <= bus.req && !valid;
               if (bus.req && valid) begin
                  state      <= DRIVE;
                  dst_q      <= bus.dst;
                  bus.busy   <= 1'b1;
                  bus.enable <= onehot(bus.src);
               end
            end
            DRIVE: begin
               state     <= CAPTURE;
               bus.latch <= onehot(dst_q);
            end
            CAPTURE: begin
               state          <= DONE;
               bus.enable     <= '0;
               bus.latch      <= '0;
               bus.done       <= 1'b1;
               bus.xfer_count <= bus.xfer_count + 16'd1;
            end
            DONE: begin
               state    <= IDLE;
               bus.busy <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_bus_transfer_controller.sv
// tb_bus_transfer_controller: random and directed stimulus against a cycle-schedule model of the sequencer.
module tb_bus_transfer_controller;
   localparam int N = 8;
   localparam int W = 4;
   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;
   bus_transfer_controller_if #(.NUM_REGS(N), .SEL_WIDTH(W)) ifc ();
   bus_transfer_controller #(.NUM_REGS(N), .SEL_WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(ifc));

   int vectors = 0, miscompares = 0, cyc = 0, free_at = 0, done_seen = 0;
   logic [N-1:0] r_en[8], r_la[8];
   logic r_done[8], r_busy[8];
   logic [15:0] mcount = 16'd0;
   logic e_busy, e_done, e_err;
   logic [N-1:0] e_en, e_la;
   logic [15:0] e_cnt;
   logic [7:0] regs[N];
   logic [7:0] bus_data;

   function automatic logic [N-1:0] oh(input logic [W-1:0] i);
      logic [N-1:0] v;
      v = '0;
      v[i] = 1'b1;
      return v;
   endfunction

   task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 20 && ifc.busy !== 1'b0; i++) @(negedge clk);
      lit("wait_idle_bound", 32'(ifc.busy), 32'd0);
   endtask

   task automatic send(input int s, input int d);
      ifc.req = 1'b1;
      ifc.src = W'(s);
      ifc.dst = W'(d);
      @(negedge clk);
      ifc.req = 1'b0;
   endtask

   // register bank: enabled register drives the bus, latched register captures it
   always_comb begin
      bus_data = 8'h00;
      for (int i = 0; i < N; i++) if (ifc.enable[i]) bus_data = bus_data | regs[i];
   end
   always @(posedge clk)
      for (int i = 0; i < N; i++) if (ifc.latch[i]) regs[i] = bus_data;

   // model: an accepted request at edge c books outputs for cycles c, c+1, c+2 and frees the sequencer at c+4
   always @(posedge clk) begin
      int c0, c1, c2;
      c0 = cyc % 8;
      c1 = (cyc + 1) % 8;
      c2 = (cyc + 2) % 8;
      e_err = 1'b0;
      if (reset) begin
         for (int i = 0; i < 8; i++) begin
            r_en[i] = '0; r_la[i] = '0; r_done[i] = 1'b0; r_busy[i] = 1'b0;
         end
         mcount  = 16'd0;
         free_at = cyc + 1;
      end else if (ifc.req && cyc >= free_at) begin
         if (ifc.src != ifc.dst && ifc.src < N && ifc.dst < N) begin
            r_en[c0] = oh(ifc.src); r_busy[c0] = 1'b1;
            r_en[c1] = oh(ifc.src); r_la[c1] = oh(ifc.dst); r_busy[c1] = 1'b1;
            r_busy[c2] = 1'b1; r_done[c2] = 1'b1;
            free_at = cyc + 4;
         end else e_err = 1'b1;
      end
      e_en = r_en[c0]; e_la = r_la[c0]; e_done = r_done[c0]; e_busy = r_busy[c0];
      if (e_done) mcount = mcount + 16'd1;
      e_cnt = mcount;
      r_en[c0] = '0; r_la[c0] = '0; r_done[c0] = 1'b0; r_busy[c0] = 1'b0;
      cyc++;
      #2;
      vectors++;
      if ({ifc.busy, ifc.done, ifc.error, ifc.enable, ifc.latch, ifc.xfer_count} !==
          {e_busy, e_done, e_err, e_en, e_la, e_cnt}) begin
         miscompares++;
         $display("FAIL cycle %0d: got busy=%b done=%b error=%b en=%h latch=%h cnt=%h expected busy=%b done=%b error=%b en=%h latch=%h cnt=%h",
                  cyc, ifc.busy, ifc.done, ifc.error, ifc.enable, ifc.latch, ifc.xfer_count,
                  e_busy, e_done, e_err, e_en, e_la, e_cnt);
      end
      vectors++;
      if ($countones(ifc.enable) > 1 || $countones(ifc.latch) > 1 ||
          (ifc.latch != '0 && (ifc.enable == '0 || (ifc.latch & ifc.enable) != '0))) begin
         miscompares++;
         $display("FAIL strobe_invariant cycle %0d: got en=%h latch=%h expected one-hot, latch only beside a different enable",
                  cyc, ifc.enable, ifc.latch);
      end
      if (ifc.done === 1'b1) done_seen++;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected $finish");
      $fatal(1);
   end

   initial begin
      int ds;
      ifc.req = 1'b0;
      ifc.src = '0;
      ifc.dst = '0;
      for (int i = 0; i < N; i++) regs[i] = 8'(i * 8'h11);
      regs[2] = 8'hCD;
      repeat (3) @(negedge clk);
      lit("reset_busy", 32'(ifc.busy), 0);
      lit("reset_enable", 32'(ifc.enable), 0);
      lit("reset_count", 32'(ifc.xfer_count), 0);
      reset = 1'b0;
      @(negedge clk);
      send(2, 5);
      lit("t1_drive_enable", 32'(ifc.enable), 32'h04);
      lit("t1_drive_latch", 32'(ifc.latch), 0);
      @(negedge clk);
      lit("t1_capture_enable", 32'(ifc.enable), 32'h04);
      lit("t1_capture_latch", 32'(ifc.latch), 32'h20);
      @(negedge clk);
      lit("t1_done", 32'(ifc.done), 1);
      lit("t1_done_enable", 32'(ifc.enable), 0);
      lit("t1_count", 32'(ifc.xfer_count), 1);
      @(negedge clk);
      lit("t1_busy_fall", 32'(ifc.busy), 0);
      lit("t1_reg5", 32'(regs[5]), 32'hCD);
      send(3, 3);
      lit("same_idx_error", 32'(ifc.error), 1);
      lit("same_idx_busy", 32'(ifc.busy), 0);
      send(9, 1);
      lit("range_error", 32'(ifc.error), 1);
      lit("range_enable", 32'(ifc.enable), 0);
      @(negedge clk);
      lit("error_single_pulse", 32'(ifc.error), 0);
      lit("invalid_count", 32'(ifc.xfer_count), 1);
      ds = done_seen;
      ifc.req = 1'b1; ifc.src = 4'd0; ifc.dst = 4'd1;
      repeat (12) @(negedge clk);
      ifc.req = 1'b0;
      wait_idle();
      lit("hold_dones", 32'(done_seen - ds), 3);
      lit("hold_count", 32'(ifc.xfer_count), 4);
      ifc.req = 1'b1; ifc.src = 4'd4; ifc.dst = 4'd6;
      @(negedge clk);
      ifc.src = 4'd1; ifc.dst = 4'd7;
      lit("ignore_drive_enable", 32'(ifc.enable), 32'h10);
      @(negedge clk);
      ifc.req = 1'b0;
      lit("ignore_capture_enable", 32'(ifc.enable), 32'h10);
      lit("ignore_capture_latch", 32'(ifc.latch), 32'h40);
      wait_idle();
      repeat (3) @(negedge clk);
      lit("ignore_count", 32'(ifc.xfer_count), 5);
      send(0, 7);
      @(negedge clk);
      lit("rst_pre_latch", 32'(ifc.latch), 32'h80);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      lit("rst_enable", 32'(ifc.enable), 0);
      lit("rst_latch", 32'(ifc.latch), 0);
      lit("rst_busy", 32'(ifc.busy), 0);
      lit("rst_done", 32'(ifc.done), 0);
      lit("rst_count", 32'(ifc.xfer_count), 0);
      repeat (2000) begin
         @(negedge clk);
         ifc.req = $urandom_range(0, 2) != 0;
         ifc.src = W'($urandom_range(0, 9));
         ifc.dst = W'($urandom_range(0, 9));
         reset = $urandom_range(0, 199) == 0;
      end
      @(negedge clk);
      reset = 1'b0;
      ifc.req = 1'b0;
      wait_idle();
      @(negedge clk);
      force ifc.xfer_count = 16'hFFFF;
      release ifc.xfer_count;
      mcount = 16'hFFFF;
      @(negedge clk);
      lit("wrap_preload", 32'(ifc.xfer_count), 32'hFFFF);
      send(1, 2);
      repeat (2) @(negedge clk);
      lit("wrap_done", 32'(ifc.done), 1);
      lit("wrap_count", 32'(ifc.xfer_count), 0);
      repeat (3) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
